// File: rtl/dff_fault_monitor_pkg.sv
// dff_monitor_pkg
//   Shared types and constants for the flip-flop fault monitor:
//   - state_t : controller states (IDLE, WRITE, SETTLE, MONITOR)
//   - evt_t   : one logged flip event at the default array/timestamp widths
//   - FC_MAX  : saturation value of the 16-bit fault counter
//   - sat_inc : saturating increment for the fault counter
package dff_monitor_pkg;

  localparam int EVT_N    = 8;
  localparam int EVT_TS_N = 32;

  localparam logic [15:0] FC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SETTLE,
    MONITOR
  } state_t;

  typedef struct packed {
    logic [EVT_N-1:0]    mask;   // bits that changed
    logic [EVT_N-1:0]    value;  // array value after the change
    logic [EVT_TS_N-1:0] stamp;  // cycles since arming
  } evt_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == FC_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dff_fault_monitor_if.sv
// dff_fault_monitor_if
//   Event stream from the fault monitor to the host/reporting logic.
//   evt_valid  : an event is at the FIFO head
//   evt_ready  : consumer accepts the head event
//   evt_mask   : bits that changed
//   evt_value  : array value after the change
//   evt_time   : cycles since arming
//   master = monitor side, slave = consumer side.
interface dff_fault_monitor_if #(
  parameter int N    = 8,
  parameter int TS_N = 32
) ();

  logic            evt_valid;
  logic            evt_ready;
  logic [N-1:0]    evt_mask;
  logic [N-1:0]    evt_value;
  logic [TS_N-1:0] evt_time;

  modport master (
    output evt_valid,
    output evt_mask,
    output evt_value,
    output evt_time,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_mask,
    input  evt_value,
    input  evt_time,
    output evt_ready
  );

endinterface

// File: rtl/dff_fault_monitor_event_fifo.sv
// event_fifo
//   Synchronous FIFO holding flip events.
//   clk, reset : clock, asynchronous active-high reset (pointers/count only)
//   push, din  : write request and payload; accepted when not full, or when
//                full and a pop happens in the same cycle
//   pop        : read request; ignored when empty
//   dout       : head entry, stable until popped
//   full/empty : occupancy flags
//   DEPTH must be a power of two so the pointers wrap naturally.
module event_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only pointers/count define which
  // entries are valid, so clearing the data would cost logic for nothing.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/dff_fault_monitor.sv
// dff_fault_monitor
//   Write-and-watch controller for the laser-target flip-flop array. Loads a
//   pattern through ff_en/ff_d, waits SETTLE_CYCLES for the debounced output
//   to settle, then logs every change of the synchronized array output as a
//   timestamped event into a small FIFO drained through the evt interface.
//
//   clk, reset   : 100 MHz clock, asynchronous active-high reset
//   start, stop  : one-cycle control pulses (stop wins over start)
//   pattern      : value to load into the array
//   ff_en, ff_d  : write port to the array (one-cycle pulse in WRITE)
//   ff_q_db      : debounced array output, asynchronous, 2-flop synchronized
//   busy, armed  : state != IDLE, state == MONITOR
//   overflow     : sticky, an event was dropped on a full FIFO
//   fault_count  : saturating count of detected events, dropped ones included
//   evt          : event stream (valid/ready, mask, value, time)
//
//   Optional: define DFF_MONITOR_AUTO_RESTORE_EN to rewrite the array and
//   re-settle after every event (timestamp keeps running across the
//   re-settle). Without it the block stays in MONITOR and tracks the faulted
//   value so only further changes are logged.
module dff_fault_monitor
  import dff_monitor_pkg::*;
#(
  parameter int N             = EVT_N,
  parameter int SETTLE_CYCLES = 20004,
  parameter int SETTLE_N      = 15,
  parameter int TS_N          = EVT_TS_N,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                stop,
  input  logic [N-1:0]        pattern,
  output logic                ff_en,
  output logic [N-1:0]        ff_d,
  input  logic [N-1:0]        ff_q_db,
  output logic                busy,
  output logic                armed,
  output logic                overflow,
  output logic [15:0]         fault_count,
  dff_fault_monitor_if.master evt
);

  typedef struct packed {
    logic [N-1:0]    mask;
    logic [N-1:0]    value;
    logic [TS_N-1:0] stamp;
  } evt_w_t;

  localparam logic [SETTLE_N-1:0] SETTLE_LAST = SETTLE_N'(SETTLE_CYCLES - 1);

  state_t              state;
  logic [N-1:0]        exp_r;
  logic [N-1:0]        last_q;
  logic [N-1:0]        q_s1;
  logic [N-1:0]        q_s;
  logic [SETTLE_N-1:0] settle_cnt;
  logic [TS_N-1:0]     ts;
  logic                ev_pend;
  evt_w_t              ev_data;
  evt_w_t              head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic                fifo_drop;
  logic                changed;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
  logic                restore_r;  // current settle follows an auto-restore
`endif

  // Two-flop synchronizer: q_s is the only consumer-visible copy of ff_q_db.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_s1 <= '0;
      q_s  <= '0;
    end else begin
      q_s1 <= ff_q_db;
      q_s  <= q_s1;
    end
  end

  assign changed   = (q_s != last_q);
  assign fifo_pop  = evt.evt_valid && evt.evt_ready;
  // A pop in the same cycle frees a slot, so only a full FIFO without pop drops.
  assign fifo_drop = ev_pend && fifo_full && !fifo_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      exp_r       <= '0;
      last_q      <= '0;
      settle_cnt  <= '0;
      ts          <= '0;
      ev_pend     <= 1'b0;
      ev_data     <= '0;
      ff_en       <= 1'b0;
      ff_d        <= '0;
      overflow    <= 1'b0;
      fault_count <= '0;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
      restore_r   <= 1'b0;
`endif
    end else begin
      ev_pend <= 1'b0;
      ff_en   <= 1'b0;
      ff_d    <= '0;

      if (fifo_drop) overflow <= 1'b1;

      // Compare stage: one event per cycle, multi-bit changes merged.
      if (state == MONITOR) begin
        ts <= ts + TS_N'(1);
        if (changed) begin
          ev_pend       <= 1'b1;
          ev_data.mask  <= q_s ^ last_q;
          ev_data.value <= q_s;
          ev_data.stamp <= ts;
          last_q        <= q_s;
          fault_count   <= sat_inc(fault_count);
        end
      end

      case (state)
        IDLE: begin
          if (start && !stop) begin
            state       <= WRITE;
            exp_r       <= pattern;
            ff_en       <= 1'b1;
            ff_d        <= pattern;
            overflow    <= 1'b0;
            fault_count <= '0;
            ts          <= '0;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
            restore_r   <= 1'b0;
`endif
          end
        end

        WRITE: begin
          if (stop) begin
            state <= IDLE;
          end else begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end

        SETTLE: begin
          if (stop) begin
            state <= IDLE;
          end else if (settle_cnt == SETTLE_LAST) begin
            state  <= MONITOR;
            last_q <= exp_r;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
            if (!restore_r) ts <= '0;
            restore_r <= 1'b0;
`else
            ts     <= '0;
`endif
          end else begin
            settle_cnt <= settle_cnt + SETTLE_N'(1);
          end
        end

        MONITOR: begin
          if (stop) begin
            state <= IDLE;
          end else if (start) begin
            state <= WRITE;
            exp_r <= pattern;
            ff_en <= 1'b1;
            ff_d  <= pattern;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
            restore_r <= 1'b0;
          end else if (changed) begin
            // Rewrite the array with the expected pattern and re-settle.
            state     <= WRITE;
            ff_en     <= 1'b1;
            ff_d      <= exp_r;
            restore_r <= 1'b1;
`endif
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(evt_w_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ev_pend),
    .pop   (fifo_pop),
    .din   (ev_data),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign busy          = (state != IDLE);
  assign armed         = (state == MONITOR);
  assign evt.evt_valid = !fifo_empty;
  // Fields read as zero when no event is held, so reset leaves all outputs 0.
  assign evt.evt_mask  = fifo_empty ? '0 : head.mask;
  assign evt.evt_value = fifo_empty ? '0 : head.value;
  assign evt.evt_time  = fifo_empty ? '0 : head.stamp;

endmodule

// File: tb/tb_dff_fault_monitor.sv
// tb_dff_fault_monitor
//   Self-checking bench for dff_fault_monitor: directed scenarios plus a
//   randomized run, all compared every cycle against a transaction-level
//   reference model (event queue, sync delay line, settle countdown).
module tb_dff_fault_monitor;
  import dff_monitor_pkg::*;

  localparam int N     = 8;
  localparam int TS_N  = 32;
  localparam int S     = 40;
  localparam int SN    = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [N-1:0]  pattern;
  logic          ff_en;
  logic [N-1:0]  ff_d;
  logic [N-1:0]  ff_q_db;
  logic          busy;
  logic          armed;
  logic          overflow;
  logic [15:0]   fault_count;

  dff_fault_monitor_if #(.N(N), .TS_N(TS_N)) evt_if ();

  dff_fault_monitor #(
    .N             (N),
    .SETTLE_CYCLES (S),
    .SETTLE_N      (SN),
    .TS_N          (TS_N),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pattern     (pattern),
    .ff_en       (ff_en),
    .ff_d        (ff_d),
    .ff_q_db     (ff_q_db),
    .busy        (busy),
    .armed       (armed),
    .overflow    (overflow),
    .fault_count (fault_count),
    .evt         (evt_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  evt_t         mq[$];
  bit           m_pend;
  evt_t         m_pend_evt;
  logic [N-1:0] m_exp, m_last, m_s1, m_s2;
  logic [31:0]  m_ts;
  logic [15:0]  m_fc;
  bit           m_ovf, m_mon, m_en, m_restore;
  int           m_arm;       // edges left until MONITOR (0 = not settling)
  int           cyc = 0;
  int           arm_cyc = 0;

  task automatic m_reset();
    mq.delete();
    m_pend = 0; m_pend_evt = '0;
    m_exp = '0; m_last = '0; m_s1 = '0; m_s2 = '0;
    m_ts = '0; m_fc = '0;
    m_ovf = 0; m_mon = 0; m_en = 0; m_restore = 0; m_arm = 0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs,
  // step the DUT, then compare every output.
  task automatic tick();
    bit           pop, det, idle_b;
    logic [N-1:0] e_mask, e_val;
    logic [31:0]  e_t;
    logic [N-1:0] e_d;
    logic         e_busy, e_valid;

    pop = (mq.size() != 0) && (evt_if.evt_ready === 1'b1);
    if (pop) void'(mq.pop_front());
    if (m_pend) begin
      if (mq.size() < DEPTH) mq.push_back(m_pend_evt);
      else m_ovf = 1;
    end
    m_pend = 0;
    det = 0;
    if (m_mon) begin
      if (m_s2 != m_last) begin
        m_pend_evt.mask  = m_s2 ^ m_last;
        m_pend_evt.value = m_s2;
        m_pend_evt.stamp = m_ts;
        m_pend = 1;
        det = 1;
        m_last = m_s2;
        if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
      end
      m_ts = m_ts + 32'd1;
    end
    m_s2 = m_s1;
    m_s1 = ff_q_db;

    idle_b = !m_mon && !m_en && (m_arm == 0);
    m_en = 0;
    if (stop && !idle_b) begin
      m_mon = 0; m_arm = 0;
    end else if (start && !stop && idle_b) begin
      m_exp = pattern; m_ovf = 0; m_fc = '0; m_ts = '0; m_restore = 0;
      m_en = 1; m_arm = S + 1;
    end else if (start && !stop && m_mon) begin
      m_exp = pattern; m_mon = 0; m_en = 1; m_arm = S + 1; m_restore = 0;
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
    end else if (det) begin
      m_mon = 0; m_en = 1; m_arm = S + 1; m_restore = 1;
`endif
    end else if (m_arm > 0) begin
      m_arm = m_arm - 1;
      if (m_arm == 0) begin
        m_mon = 1;
        m_last = m_exp;
        if (!m_restore) m_ts = '0;
        m_restore = 0;
        arm_cyc = cyc + 1;
      end
    end

    @(posedge clk);
    #1;
    cyc++;

    e_valid = (mq.size() != 0);
    e_mask  = e_valid ? mq[0].mask  : '0;
    e_val   = e_valid ? mq[0].value : '0;
    e_t     = e_valid ? mq[0].stamp : '0;
    e_d     = m_en ? m_exp : '0;
    e_busy  = m_mon || m_en || (m_arm > 0);

    checks++;
    if ({ff_en, ff_d, busy, armed, evt_if.evt_valid, evt_if.evt_mask, evt_if.evt_value,
         evt_if.evt_time, overflow, fault_count} !==
        {m_en, e_d, e_busy, m_mon, e_valid, e_mask, e_val, e_t, m_ovf, m_fc}) begin
      errors++;
      $display("FAIL cycle_model @%0d: got en=%b d=%h busy=%b armed=%b valid=%b mask=%h value=%h time=%0d ovf=%b fc=%0d; expected en=%b d=%h busy=%b armed=%b valid=%b mask=%h value=%h time=%0d ovf=%b fc=%0d",
               cyc, ff_en, ff_d, busy, armed, evt_if.evt_valid, evt_if.evt_mask, evt_if.evt_value,
               evt_if.evt_time, overflow, fault_count,
               m_en, e_d, e_busy, m_mon, e_valid, e_mask, e_val, e_t, m_ovf, m_fc);
    end

    // Behave like the array: a write lands on the debounced output.
    if (m_en) ff_q_db = m_exp;
  endtask

  // Return to IDLE, start a run with pattern p and wait until the model arms.
  task automatic arm_run(input logic [N-1:0] p);
    stop = 1; tick(); stop = 0;
    pattern = p; start = 1; tick(); start = 0;
    for (int i = 0; i < 2 * S && !m_mon; i++) tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; start = 0; stop = 0; pattern = '0; ff_q_db = '0;
    evt_if.evt_ready = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ff_en, ff_d, busy, armed, evt_if.evt_valid, overflow, fault_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got en=%b d=%h busy=%b armed=%b valid=%b ovf=%b fc=%0d, expected all 0",
               ff_en, ff_d, busy, armed, evt_if.evt_valid, overflow, fault_count);
    end
    checks++;
    if ({evt_if.evt_mask, evt_if.evt_value, evt_if.evt_time} !== '0) begin
      errors++;
      $display("FAIL reset_evt_fields: got mask=%h value=%h time=%0d, expected 0",
               evt_if.evt_mask, evt_if.evt_value, evt_if.evt_time);
    end
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_write_arm();
    int n;
    bit seen;
    pattern = 8'hA5; start = 1; tick(); start = 0;
    checks++;
    if (ff_en !== 1'b1 || ff_d !== 8'hA5) begin
      errors++;
      $display("FAIL write_pulse: got ff_en=%b ff_d=%h, expected 1 a5", ff_en, ff_d);
    end
    n = 0; seen = 0;
    for (int i = 0; i < 2 * S; i++) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (ff_en !== 1'b0) begin
          errors++;
          $display("FAIL write_single_cycle: got ff_en=%b, expected 0", ff_en);
        end
      end
      if (armed === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || n != S + 1) begin
      errors++;
      $display("FAIL arm_delay: got armed after %0d edges (seen=%0d), expected %0d", n, seen, S + 1);
    end
    checks++;
    if (evt_if.evt_valid !== 1'b0 || fault_count !== 16'd0) begin
      errors++;
      $display("FAIL arm_no_events: got valid=%b fc=%0d, expected 0 0", evt_if.evt_valid, fault_count);
    end
  endtask

  task automatic test_single_flip();
    int present;
    ff_q_db = 8'hA4;
    present = cyc + 1;  // first edge that samples the new value
    repeat (3) tick();  // edges k .. k+2
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flip_latency_early: got valid=%b at edge k+2, expected 0", evt_if.evt_valid);
    end
    tick();             // edge k+3
    checks++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_mask !== 8'h01 || evt_if.evt_value !== 8'hA4 ||
        evt_if.evt_time !== 32'(present + 2 - arm_cyc - 1) || fault_count !== 16'd1) begin
      errors++;
      $display("FAIL flip_event: got valid=%b mask=%h value=%h time=%0d fc=%0d, expected 1 01 a4 %0d 1",
               evt_if.evt_valid, evt_if.evt_mask, evt_if.evt_value, evt_if.evt_time, fault_count,
               present + 1 - arm_cyc);
    end
    // Head must hold while not ready.
    tick();
    checks++;
    if (evt_if.evt_valid !== 1'b1 || evt_if.evt_mask !== 8'h01) begin
      errors++;
      $display("FAIL flip_hold: got valid=%b mask=%h, expected 1 01", evt_if.evt_valid, evt_if.evt_mask);
    end
    evt_if.evt_ready = 1'b1; tick(); evt_if.evt_ready = 1'b0;
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL flip_drain: got valid=%b, expected 0", evt_if.evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [N-1:0] v;
    logic [N-1:0] vals[5];
    logic [31:0]  t0;
    evt_if.evt_ready = 1'b0;
    arm_run(8'hC3);
    v = 8'hC3;
    for (int i = 0; i < 5; i++) begin
      v = v ^ (8'h01 << i);
      vals[i] = v;
      ff_q_db = v;
      tick();
    end
    repeat (4) tick();
    checks++;
    if (fault_count !== 16'd5 || overflow !== 1'b1 || evt_if.evt_valid !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: got fc=%0d ovf=%b valid=%b, expected 5 1 1",
               fault_count, overflow, evt_if.evt_valid);
    end
    t0 = evt_if.evt_time;
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (evt_if.evt_valid !== 1'b1 || evt_if.evt_mask !== (8'h01 << i) ||
          evt_if.evt_value !== vals[i] || evt_if.evt_time !== t0 + 32'(i)) begin
        errors++;
        $display("FAIL overflow_drain[%0d]: got valid=%b mask=%h value=%h time=%0d, expected 1 %h %h %0d",
                 i, evt_if.evt_valid, evt_if.evt_mask, evt_if.evt_value, evt_if.evt_time,
                 8'h01 << i, vals[i], t0 + 32'(i));
      end
      tick();
    end
    evt_if.evt_ready = 1'b0;
    checks++;
    if (evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_empty: got valid=%b, expected 0", evt_if.evt_valid);
    end
  endtask

  task automatic test_settle_ignore();
    stop = 1; tick(); stop = 0;
    pattern = 8'h5A; start = 1; tick(); start = 0;
    repeat (5) tick();
    ff_q_db = 8'h5A ^ 8'hFF;
    repeat (10) tick();
    ff_q_db = 8'h5A;
    for (int i = 0; i < 2 * S && !m_mon; i++) tick();
    repeat (6) tick();
    checks++;
    if (armed !== 1'b1 || fault_count !== 16'd0 || evt_if.evt_valid !== 1'b0) begin
      errors++;
      $display("FAIL settle_ignore: got armed=%b fc=%0d valid=%b, expected 1 0 0",
               armed, fault_count, evt_if.evt_valid);
    end
  endtask

  task automatic test_random();
    arm_run(8'($urandom));
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 30) ff_q_db = 8'($urandom);
      evt_if.evt_ready = 1'($urandom);
      start = ($urandom_range(0, 99) < 2);
      stop  = ($urandom_range(0, 199) < 1);
      pattern = 8'($urandom);
      tick();
      start = 0; stop = 0;
    end
    evt_if.evt_ready = 1'b1;
    repeat (8) tick();
    evt_if.evt_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    evt_if.evt_ready = 1'b0;
    arm_run(8'h3C);
    ff_q_db = ff_q_db ^ 8'h01; tick(); tick();
    ff_q_db = ff_q_db ^ 8'h02;
    repeat (6) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (evt_if.evt_valid !== 1'b0 || armed !== 1'b0 || busy !== 1'b0 || fault_count !== 16'd0 ||
        overflow !== 1'b0 || ff_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got valid=%b armed=%b busy=%b fc=%0d ovf=%b en=%b, expected all 0",
               evt_if.evt_valid, armed, busy, fault_count, overflow, ff_en);
    end
    m_reset();
    ff_q_db = '0;
    #1;
    reset = 1'b0;
    repeat (3) tick();
  endtask

`ifdef DFF_MONITOR_AUTO_RESTORE_EN
  task automatic test_auto_restore();
    int  n;
    bit  seen;
    evt_if.evt_ready = 1'b0;
    arm_run(8'hA5);
    ff_q_db = 8'h25;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ff_en === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || ff_d !== 8'hA5) begin
      errors++;
      $display("FAIL restore_write: got seen=%0d ff_d=%h, expected 1 a5", seen, ff_d);
    end
    n = 0; seen = 0;
    for (int i = 0; i < 2 * S; i++) begin
      tick();
      n++;
      if (n == 1) begin
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_mask !== 8'h80 || evt_if.evt_value !== 8'h25) begin
          errors++;
          $display("FAIL restore_event: got valid=%b mask=%h value=%h, expected 1 80 25",
                   evt_if.evt_valid, evt_if.evt_mask, evt_if.evt_value);
        end
      end
      if (armed === 1'b1) begin seen = 1; break; end
    end
    checks++;
    if (!seen || n != S + 1 || fault_count !== 16'd1) begin
      errors++;
      $display("FAIL restore_rearm: got seen=%0d edges=%0d fc=%0d, expected 1 %0d 1",
               seen, n, fault_count, S + 1);
    end
    evt_if.evt_ready = 1'b1; repeat (2) tick(); evt_if.evt_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_write_arm();
    test_single_flip();
`ifdef DFF_MONITOR_AUTO_RESTORE_EN
    test_auto_restore();
`else
    test_overflow();
`endif
    test_settle_ignore();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d errors so far", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
